// File: rtl/lane_dispatch_pkg.sv
// lane_dispatch_pkg: shared constants and width helpers for the lane dispatcher.
package lane_dispatch_pkg;

    localparam int DISPATCH_RR_RESET = 0;

    // One bit wider than the FIFO pointers so full and empty are distinct.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// dispatch_fifo: circular word buffer with occupancy count and full/empty flags.
module dispatch_fifo
    import lane_dispatch_pkg::*;
#(
    parameter int DATA_BW = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int OCC_W = occ_width(FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [DATA_BW-1:0] push_data_i,
    input  logic               pop_i,
    output logic [DATA_BW-1:0] head_o,
    output logic [OCC_W-1:0]   occupancy_o,
    output logic               full_o,
    output logic               empty_o
);

    logic [DATA_BW-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               do_push, do_pop;

    assign full_o      = occ_q == OCC_W'(FIFO_DEPTH);
    assign empty_o     = occ_q == '0;
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign head_o      = mem_q[rd_q];
    assign occupancy_o = occ_q;

    always_comb begin
        wr_d  = do_push ? (wr_q == PTR_W'(FIFO_DEPTH - 1) ? '0 : wr_q + PTR_W'(1)) : wr_q;
        rd_d  = do_pop ? (rd_q == PTR_W'(FIFO_DEPTH - 1) ? '0 : rd_q + PTR_W'(1)) : rd_q;
        occ_d = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/lane_dispatch.sv
// lane_dispatch: buffers a word stream and hands each word to the next ready lane
// in round-robin order, driving a demux through registered data/sel/valid.
module lane_dispatch
    import lane_dispatch_pkg::*;
#(
    parameter int NUM_DATA = 2,
    parameter int DATA_BW = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int SEL_WIDTH = $clog2(NUM_DATA),
    localparam int OCC_W = occ_width(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATA_BW-1:0]   in_data,
    output logic                 in_ready,
    input  logic [NUM_DATA-1:0]  lane_ready,
    output logic [DATA_BW-1:0]   out_data,
    output logic [SEL_WIDTH-1:0] out_sel,
    output logic                 out_valid,
    output logic [OCC_W-1:0]     occupancy
);

    logic [SEL_WIDTH-1:0] rr_q, rr_d, pick, idx;
    logic [SEL_WIDTH:0]   sum;
    logic [DATA_BW-1:0]   head, out_data_q;
    logic [SEL_WIDTH-1:0] out_sel_q;
    logic                 out_valid_q, full, empty, dispatch;

    dispatch_fifo #(
        .DATA_BW   (DATA_BW),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (in_valid),
        .push_data_i(in_data),
        .pop_i      (dispatch),
        .head_o     (head),
        .occupancy_o(occupancy),
        .full_o     (full),
        .empty_o    (empty)
    );

    assign in_ready  = !full;
    assign dispatch  = !empty && |lane_ready;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

    // Scan farthest-first so the ready lane closest to rr_q overwrites the rest.
    always_comb begin
        pick = rr_q;
        sum  = '0;
        idx  = '0;
        for (int k = NUM_DATA - 1; k >= 0; k--) begin
            sum = {1'b0, rr_q} + (SEL_WIDTH + 1)'(k);
            idx = sum >= (SEL_WIDTH + 1)'(NUM_DATA) ? SEL_WIDTH'(sum - (SEL_WIDTH + 1)'(NUM_DATA)) : SEL_WIDTH'(sum);
            if (lane_ready[idx]) pick = idx;
        end
        rr_d = pick == SEL_WIDTH'(NUM_DATA - 1) ? '0 : pick + SEL_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_q        <= SEL_WIDTH'(DISPATCH_RR_RESET);
        end else begin
            out_valid_q <= dispatch;
            if (dispatch) begin
                out_data_q <= head;
                out_sel_q  <= pick;
                rr_q       <= rr_d;
            end
        end
    end

endmodule
